// File: rtl/audio_pkg.sv
// Shared types for the audio DAC transmit path.
package audio_pkg;

   localparam int unsigned SAMPLE_W = 16;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   typedef enum logic [1:0] {ALIGN, LOAD, SHIFT, PAD} tx_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO: rdata_o always presents the head entry, so a pop
// and the read of that entry happen in the same cycle.
module sample_fifo #(
   parameter int unsigned Width = 16,
   parameter int unsigned Depth = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clr_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [Width-1:0]         wdata_i,
   output logic [Width-1:0]         rdata_o,
   output logic [$clog2(Depth):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned AddrW = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AddrW:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AddrW+1)'(Depth));
   assign do_pop  = pop_i & ~empty_o;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign do_push = push_i & (~full_o | do_pop);
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + (AddrW+1)'(do_push) - (AddrW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/audio_dac_tx.sv
// I2S transmitter slaved to codec BCLK/DACLRCK: buffers mono samples and sends
// each one on both the left and right slot, MSB first with a one-bit delay.
module audio_dac_tx
   import audio_pkg::*;
#(
   parameter int unsigned DATA_W     = SAMPLE_W,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned SLOT_W     = 32
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_valid,
   input  logic [DATA_W-1:0]             i_data,
   input  logic                          i_enable,
   input  logic                          i_clr_status,
   input  logic                          i_bclk,
   input  logic                          i_daclrck,
   output logic                          o_dacdat,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
   output logic                          o_overflow,
   output logic                          o_underflow
);

   localparam int unsigned CntW = $clog2(SLOT_W);

   logic bclk_s1_q, bclk_s2_q, bclk_s3_q, lrck_s1_q, lrck_s2_q;
   logic rise_q, fall_q, evt_q, lrck_cur_q, lrck_prev_q;

   tx_state_e          state_q, state_d;
   logic [DATA_W-1:0]  shift_q, shift_d, hold_q, hold_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               dacdat_q, dacdat_d;
   logic               ovf_q, ovf_d, udf_q, udf_d, udf_set;

   logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [DATA_W-1:0]  fifo_rdata;
   logic               left_start, chan_start;

   // Codec clocks are sampled as data; events are registered one stage past the edge flop.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         bclk_s1_q   <= 1'b0;
         bclk_s2_q   <= 1'b0;
         bclk_s3_q   <= 1'b0;
         lrck_s1_q   <= 1'b0;
         lrck_s2_q   <= 1'b0;
         rise_q      <= 1'b0;
         fall_q      <= 1'b0;
         evt_q       <= 1'b0;
         lrck_cur_q  <= 1'b0;
         lrck_prev_q <= 1'b0;
      end else begin
         bclk_s1_q <= i_bclk;
         bclk_s2_q <= bclk_s1_q;
         bclk_s3_q <= bclk_s2_q;
         lrck_s1_q <= i_daclrck;
         lrck_s2_q <= lrck_s1_q;
         rise_q    <= bclk_s2_q & ~bclk_s3_q;
         fall_q    <= ~bclk_s2_q & bclk_s3_q;
         evt_q     <= rise_q;
         if (rise_q) begin
            lrck_cur_q  <= lrck_s2_q;
            lrck_prev_q <= lrck_cur_q;
         end
      end
   end

   assign left_start = evt_q & lrck_prev_q & ~lrck_cur_q;
   assign chan_start = evt_q & (lrck_prev_q ^ lrck_cur_q);

   assign fifo_push = i_valid & i_enable;
   assign fifo_pop  = i_enable & (state_q == LOAD) & ~lrck_cur_q & ~fifo_empty;

   sample_fifo #(
      .Width (DATA_W),
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (i_clk),
      .rst_i   (i_rst),
      .clr_i   (~i_enable),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i (i_data),
      .rdata_o (fifo_rdata),
      .count_o (o_fifo_level),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      hold_d   = hold_q;
      cnt_d    = cnt_q;
      dacdat_d = dacdat_q;
      udf_set  = 1'b0;
      if (!i_enable) begin
         state_d  = ALIGN;
         shift_d  = '0;
         hold_d   = '0;
         cnt_d    = '0;
         dacdat_d = 1'b0;
      end else begin
         unique case (state_q)
            ALIGN: begin
               dacdat_d = 1'b0;
               if (left_start) state_d = LOAD;
            end
            LOAD: begin
               // Left slot takes a fresh sample; right slot repeats it.
               if (!lrck_cur_q) begin
                  hold_d  = fifo_empty ? '0 : fifo_rdata;
                  udf_set = fifo_empty;
               end
               shift_d = hold_d;
               cnt_d   = '0;
               state_d = SHIFT;
            end
            SHIFT: begin
               if (chan_start) begin
                  state_d = LOAD;
               end else if (fall_q) begin
                  dacdat_d = shift_q[DATA_W-1];
                  shift_d  = {shift_q[DATA_W-2:0], 1'b0};
                  cnt_d    = cnt_q + 1'b1;
                  if (cnt_q == CntW'(DATA_W-1)) state_d = PAD;
               end
            end
            PAD: begin
               if (chan_start) begin
                  state_d = LOAD;
               end else if (fall_q) begin
                  dacdat_d = 1'b0;
                  if (cnt_q != CntW'(SLOT_W-1)) cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = ALIGN;
         endcase
      end
      ovf_d = (fifo_push & fifo_full & ~fifo_pop) ? 1'b1 : (i_clr_status ? 1'b0 : ovf_q);
      udf_d = udf_set ? 1'b1 : (i_clr_status ? 1'b0 : udf_q);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= ALIGN;
         shift_q  <= '0;
         hold_q   <= '0;
         cnt_q    <= '0;
         dacdat_q <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         hold_q   <= hold_d;
         cnt_q    <= cnt_d;
         dacdat_q <= dacdat_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   assign o_dacdat    = dacdat_q;
   assign o_overflow  = ovf_q;
   assign o_underflow = udf_q;

endmodule

// File: tb/tb_audio_dac_tx.sv
// Bench for audio_dac_tx: drives codec clocks, predicts every serial bit from a
// frame-level model and checks them in a separate monitor.
module tb_audio_dac_tx;
   import audio_pkg::*;

   localparam int Depth = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic [15:0] data = '0;
   logic        enable = 1'b0;
   logic        clr_status = 1'b0;
   logic        bclk = 1'b1;
   logic        lrck = 1'b1;
   logic        dacdat;
   logic [2:0]  level;
   logic        ovf, udf;

   int checks = 0;
   int errors = 0;
   logic exp_q[$];
   logic mon_en = 1'b0;
   logic mon_e;

   // Frame-level reference model.
   sample_t m_fifo[$];
   sample_t m_hold;
   bit m_aligned, m_live, m_last, m_ovf, m_udf, m_en;

   audio_dac_tx dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_valid      (valid),
      .i_data       (data),
      .i_enable     (enable),
      .i_clr_status (clr_status),
      .i_bclk       (bclk),
      .i_daclrck    (lrck),
      .o_dacdat     (dacdat),
      .o_fifo_level (level),
      .o_overflow   (ovf),
      .o_underflow  (udf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge bclk) begin
      if (mon_en) begin
         if (exp_q.size() == 0) begin
            check("dacdat_scoreboard_empty", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("dacdat_bit", 32'(dacdat), 32'(mon_e));
         end
      end
   end

   task automatic model_reset();
      m_fifo.delete();
      m_hold = '0;
      m_aligned = 0;
      m_live = 0;
      m_last = 0;
      m_ovf = 0;
      m_udf = 0;
   endtask

   task automatic model_push(input sample_t s);
      if (m_en) begin
         if (m_fifo.size() == Depth) m_ovf = 1;
         else m_fifo.push_back(s);
      end
   endtask

   // LRCK as seen at the first BCLK rise of a slot decides what the slot carries.
   task automatic model_slot_start(input bit lr);
      bit start;
      start = (lr != m_last);
      m_last = lr;
      m_live = 0;
      if (m_en) begin
         if (start && !lr) m_aligned = 1;
         if (m_aligned && start) begin
            if (!lr) begin
               if (m_fifo.size() == 0) begin
                  m_hold = '0;
                  m_udf = 1;
               end else begin
                  m_hold = m_fifo.pop_front();
               end
            end
            m_live = 1;
         end
      end
   endtask

   task automatic check_status(input string tag);
      check({tag, "_level"}, 32'(level), 32'(m_fifo.size()));
      check({tag, "_overflow"}, 32'(ovf), 32'(m_ovf));
      check({tag, "_underflow"}, 32'(udf), 32'(m_udf));
   endtask

   task automatic push_list(input sample_t v[$]);
      foreach (v[i]) begin
         @(negedge clk);
         valid = 1'b1;
         data = v[i];
         model_push(v[i]);
      end
      @(negedge clk);
      valid = 1'b0;
   endtask

   // 32 BCLK periods of 16 i_clk each; optional reset pulse after fall rst_bit.
   task automatic run_slot(input bit lr, input int rst_bit);
      logic eb;
      @(negedge clk);
      for (int k = 0; k < 32; k++) begin
         bclk = 1'b0;
         if (k == 0) begin
            lrck = lr;
            model_slot_start(lr);
         end
         if (k == rst_bit) begin
            repeat (5) @(negedge clk);
            rst = 1'b1;
            #1;
            check("rst_dacdat", 32'(dacdat), 32'd0);
            check("rst_level", 32'(level), 32'd0);
            model_reset();
            @(negedge clk);
            rst = 1'b0;
            repeat (2) @(negedge clk);
         end else begin
            repeat (8) @(negedge clk);
         end
         eb = (m_live && k >= 1 && k <= 16) ? m_hold[16-k] : 1'b0;
         exp_q.push_back(eb);
         bclk = 1'b1;
         repeat (8) @(negedge clk);
      end
   endtask

   task automatic run_frame();
      run_slot(1'b0, -1);
      run_slot(1'b1, -1);
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr_status = 1'b1;
      @(negedge clk);
      clr_status = 1'b0;
      m_ovf = 0;
      m_udf = 0;
   endtask

   task automatic set_enable(input bit en);
      @(negedge clk);
      enable = en;
      m_en = en;
      if (!en) begin
         m_fifo.delete();
         m_aligned = 0;
         m_live = 0;
         m_hold = '0;
      end
   endtask

   initial begin
      sample_t v[$];
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_dacdat", 32'(dacdat), 32'd0);
      check_status("reset");
      rst = 1'b0;
      mon_en = 1'b1;
      set_enable(1'b1);

      // Warm-up right slot so the first frame starts with a real left edge.
      run_slot(1'b1, -1);

      v = '{16'sh8001};
      push_list(v);
      check_status("push_8001");
      run_frame();
      check_status("frame_8001");

      v = '{16'sh1234, 16'sh8000};
      push_list(v);
      check_status("two_pushed");
      run_frame();
      check_status("frame_1234");
      run_frame();
      check_status("frame_8000");

      run_frame();
      check_status("empty_frame");
      pulse_clr();
      check_status("clr_underflow");

      v.delete();
      for (int i = 0; i < 6; i++) v.push_back(sample_t'($urandom));
      push_list(v);
      check_status("overflow_burst");
      for (int i = 0; i < 4; i++) begin
         run_frame();
         check_status("drain");
      end
      pulse_clr();
      check_status("clr_overflow");

      for (int it = 0; it < 10; it++) begin
         v.delete();
         for (int i = 0; i < int'($urandom_range(0, 3)); i++) v.push_back(sample_t'($urandom));
         if (v.size() != 0) push_list(v);
         check_status("rand_push");
         if ($urandom_range(0, 3) == 0) pulse_clr();
         run_frame();
         check_status("rand_frame");
      end

      // Reset in the middle of a left slot carrying all ones.
      pulse_clr();
      v = '{16'shFFFF, 16'sh7AAA};
      push_list(v);
      run_slot(1'b0, 8);
      check_status("after_reset");
      v = '{16'shA5A5};
      push_list(v);
      run_slot(1'b1, -1);
      check_status("reset_wait_align");
      run_frame();
      check_status("reset_realigned");

      v = '{16'sh0F0F, 16'sh3C3C, 16'sh5555};
      push_list(v);
      check_status("pre_disable");
      set_enable(1'b0);
      @(posedge clk);
      #1;
      check("disable_level", 32'(level), 32'd0);
      v = '{16'sh7777};
      push_list(v);
      check_status("disabled_push");
      run_frame();
      set_enable(1'b1);
      v = '{16'sh4321};
      push_list(v);
      run_slot(1'b1, -1);
      check_status("reenable_wait");
      run_frame();
      check_status("reenable_frame");

      repeat (4) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/audio_dac_tx.md
Name: audio_dac_tx

Overview:
- Sink end of the effect-chain sample interface (valid-qualified signed 16-bit mono samples, e.g. Effect_Tremolo o_data/o_valid).
- Buffers samples in a small FIFO and serialises them to the audio codec DAC in I2S format, slaved to codec-driven BCLK/DACLRCK.
- Codec clocks are treated as data: synchronised and edge-detected in the single i_clk domain.
- Each sample is sent on both channels (mono duplicate).

Parameters:
- DATA_W, 16, sample width and bits per channel slot.
- FIFO_DEPTH, 4, sample buffer entries (power of 2, ≥2).
- SLOT_W, 32, max BCLK periods per LRCK half-frame; sizes bit counter.

Ports:
- i_clk  in  1  system clock; must be ≥8× BCLK frequency.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  one-cycle strobe: i_data holds a sample.
- i_data  in  DATA_W  signed sample, two's complement.
- i_enable  in  1  0: flush FIFO, drive o_dacdat=0, realign to frame.
- i_clr_status  in  1  pulse: clears o_overflow/o_underflow.
- i_bclk  in  1  codec bit clock (asynchronous).
- i_daclrck  in  1  codec LR clock (asynchronous); 0 = left, 1 = right.
- o_dacdat  out  1  serial data to codec.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- o_overflow  out  1  sticky: sample dropped on a full FIFO.
- o_underflow  out  1  sticky: frame started with an empty FIFO.

Behaviour:
- Reset (async on i_rst high): o_dacdat=0, o_fifo_level=0, o_overflow=0, o_underflow=0, state=ALIGN, shift reg=0, hold reg=0, sync flops=0.
- Synchronisers: i_bclk and i_daclrck each pass through 2 flops, plus a third for edge detect. bclk_rise/bclk_fall are one-cycle events.
- Sampling: LRCK is sampled only on bclk_rise events (lrck_cur), with the previous sample kept as lrck_prev.
- Frame boundaries: a left start is lrck 1->0; a right start is lrck 0->1.
- Push: on i_valid && i_enable. If the FIFO is full, the sample is dropped and o_overflow is set. Push and pop in the same cycle are both legal, including when full (the pop frees a slot first).
- States:
  - ALIGN: o_dacdat=0. Go to LOAD on the first left start seen at a bclk_rise.
  - LOAD: entered at a channel-start bclk_rise.
    - Left start: pop FIFO into hold reg. If the FIFO is empty, hold=0 and o_underflow is set.
    - Right start: reuse hold reg.
    - Shift reg <= hold; bit_cnt <= 0; go to SHIFT.
  - SHIFT: on each bclk_fall, o_dacdat <= shift reg MSB, shift left, bit_cnt++. So the MSB appears on the first BCLK fall after the LRCK transition (I2S one-bit delay). After DATA_W bits go to PAD.
  - PAD: on each bclk_fall, o_dacdat <= 0. A channel start at bclk_rise goes to LOAD.
- Early LRCK edge: a channel start arriving in SHIFT before DATA_W bits is a truncated slot. The block goes to LOAD immediately with no error flag.
- Width mismatch: if SLOT_W-1 bclk_fall events pass with no LRCK edge, the bit counter saturates. The block stays in PAD (no wrap).
- i_enable low: synchronously clears FIFO and hold reg, o_dacdat=0, state=ALIGN. The sticky flags are kept.
- i_clr_status: clears both sticky flags. A set event in the same cycle wins.
- Latency: o_dacdat updates 4 i_clk cycles after a raw i_bclk falling edge (2 sync + 1 edge + 1 output register).
- Pop timing: a pop happens once per frame, at the left start; the right channel repeats the sample.
- Reset mid-frame: all state is lost, and after release the block waits in ALIGN for the next left start.

Decomposition:
- Package audio_pkg: SAMPLE_W=16, sample_t (logic signed [15:0]), tx_state_e {ALIGN, LOAD, SHIFT, PAD}.
- One sub-module: sample_fifo (parameterised sync FIFO with count/full/empty). Used as a show-ahead FIFO so the pop and the data read happen in the same cycle.

Test Plan:
- Push 16'sh8001, then run a 64-BCLK frame (BCLK = i_clk/16). Required:
  - o_dacdat carries 1000_0000_0000_0001 MSB-first starting on the 1st BCLK fall after the left edge, with zeros for bits 17-32.
  - The right slot carries the same pattern.
- Push 16'sh1234 and 16'sh8000 in consecutive frames. Left/right of frame 1 carry 0x1234, frame 2 carries 0x8000, and o_fifo_level goes 2→1→0.
- Empty FIFO at a left start: the slot is all zeros and o_underflow=1. Pulse i_clr_status → o_underflow=0.
- Push 6 samples back-to-back with no frames running. Required: o_fifo_level=4, o_overflow=1, and the next frames output samples 1-4 only.
- Assert i_rst mid-SHIFT, then release. Required:
  - o_dacdat=0 and o_fifo_level=0 immediately on assertion.
  - No data until a fresh left start after release.
- i_enable=0 with 3 samples queued. Required: level→0 next cycle and o_dacdat held at 0. After re-enable, the first sample waits for the next left start.
